// File: rtl/regfile_issue_ctrl.sv
// regfile_issue_ctrl: queues register-level ops and issues them one at a time to the regfile,
// with a completion counter and a sticky watchdog on the FU result stream.
module regfile_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = 16,
  parameter int NREG = 16,
  parameter int RW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [RW-1:0]    instr_src0,
  input  logic [RW-1:0]    instr_src1,
  input  logic [RW-1:0]    instr_dst,
  input  logic             instr_use_src1,
  input  logic             register_file_ready,
  output logic             start_operation,
  output logic [RW-1:0]    source0_register_index,
  output logic [RW-1:0]    source1_register_index,
  output logic [RW-1:0]    destination_register_index,
  output logic             use_source1,
  input  logic             destination_valid,
  input  logic             destination_last,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] ops_completed,
  output logic             timeout_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 * RW + 1;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, START, RUN, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WW-1:0] wdog;
  logic fifo_empty, fifo_full, push, pop, fin, expire;
  logic [EW-1:0] head;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign instr_ready = !reset && !fifo_full && state != ERR;
  assign push = instr_valid && instr_ready;
  assign pop = state == IDLE && !fifo_empty;
  assign head = fifo_mem[rd_ptr[AW-1:0]];
  // Result beats only matter while an op is running.
  assign fin = state == RUN && destination_valid && destination_last;
  assign expire = state == RUN && !fin && TIMEOUT_CYCLES != 0 && wdog == WLAST;
  assign start_operation = state == START;
  assign done_pulse = state == DONE;
  assign timeout_error = state == ERR;
  assign busy = state != IDLE || !fifo_empty;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = fifo_empty ? IDLE : WAIT_RDY;
      WAIT_RDY: state_nx = register_file_ready ? START : WAIT_RDY;
      START:    state_nx = RUN;
      RUN:      state_nx = fin ? DONE : expire ? ERR : RUN;
      DONE:     state_nx = IDLE;
      default:  state_nx = ERR;
    endcase
  end
  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {instr_use_src1, instr_dst, instr_src1, instr_src0};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wdog <= '0;
      ops_completed <= '0;
      source0_register_index <= '0;
      source1_register_index <= '0;
      destination_register_index <= '0;
      use_source1 <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        {use_source1, destination_register_index, source1_register_index, source0_register_index} <= head;
      end
      if (state == START) wdog <= '0;
      else if (state == RUN && !fin && !expire) wdog <= wdog + WW'(1);
      if (state == DONE) ops_completed <= ops_completed + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// tb_regfile_issue_ctrl: table-driven cycle checks plus directed multi-cycle sequences
// for queueing, back-pressure, watchdog and mid-op reset.
module tb_regfile_issue_ctrl;
  localparam int RW = 4;
  logic clk = 0, reset = 1;
  logic instr_valid = 0, instr_ready, instr_use_src1 = 0, register_file_ready = 0;
  logic [RW-1:0] instr_src0 = 0, instr_src1 = 0, instr_dst = 0;
  logic start_operation, use_source1, busy, done_pulse, timeout_error;
  logic [RW-1:0] source0_register_index, source1_register_index, destination_register_index;
  logic destination_valid = 0, destination_last = 0;
  logic [15:0] ops_completed;
  int total = 0, passed = 0;
  int fu_cnt = 0, starts = 0, dones = 0, order_err = 0;
  bit fu_en = 1;
  logic [RW-1:0] start_dst [$];

  regfile_issue_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .CNT_W(16), .NREG(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_src0(instr_src0), .instr_src1(instr_src1), .instr_dst(instr_dst),
    .instr_use_src1(instr_use_src1), .register_file_ready(register_file_ready),
    .start_operation(start_operation), .source0_register_index(source0_register_index),
    .source1_register_index(source1_register_index),
    .destination_register_index(destination_register_index), .use_source1(use_source1),
    .destination_valid(destination_valid), .destination_last(destination_last), .busy(busy),
    .done_pulse(done_pulse), .ops_completed(ops_completed), .timeout_error(timeout_error));

  always #5 clk = ~clk;

  // FU model: 3 beats (last on the third) starting the cycle after a start; plus event monitor.
  always @(negedge clk) begin
    if (reset) begin
      fu_cnt = 0; destination_valid = 0; destination_last = 0;
      starts = 0; dones = 0; order_err = 0; start_dst.delete();
    end else begin
      if (fu_cnt > 0) begin
        destination_valid = 1; destination_last = fu_cnt == 1; fu_cnt--;
      end else begin
        destination_valid = 0; destination_last = 0;
        if (start_operation && fu_en) fu_cnt = 3;
      end
      if (start_operation) begin
        if (dones != starts) order_err++;
        start_dst.push_back(destination_register_index);
        starts++;
      end
      if (done_pulse) dones++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic v; logic [RW-1:0] s0, s1, d; logic u; logic rf;
    logic e_start, e_done, e_busy, e_ready; logic [RW-1:0] e_dst; logic e_use; logic [15:0] e_ops;
  } vec_t;
  vec_t tab [26];

  function automatic vec_t mk(logic v, logic [RW-1:0] s0, s1, d, logic u, logic rf,
                              logic es, ed, eb, er, logic [RW-1:0] edst, logic eu, logic [15:0] eo);
    vec_t t;
    t.v = v; t.s0 = s0; t.s1 = s1; t.d = d; t.u = u; t.rf = rf;
    t.e_start = es; t.e_done = ed; t.e_busy = eb; t.e_ready = er;
    t.e_dst = edst; t.e_use = eu; t.e_ops = eo;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [RW-1:0] a, b, d, input logic u);
    instr_src0 = a; instr_src1 = b; instr_dst = d; instr_use_src1 = u; instr_valid = 1;
    for (int k = 0; k < 100 && !instr_ready; k++) tick();
    check("push_ready", 32'(instr_ready), 1);
    tick();
    instr_valid = 0;
  endtask

  task automatic wait_dones(input int target, input int bound, input string name);
    for (int k = 0; k < bound && dones < target; k++) tick();
    check(name, dones, target);
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    for (int k = 0; k < bound && starts < target; k++) tick();
    check(name, starts, target);
  endtask

  initial begin
    // op A (0,1,2,use) with rf ready, then op B (3,4,5) held 10+ cycles in WAIT_RDY
    tab[0] = mk(1, 0, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    tab[1] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 0);
    tab[2] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 1, 0);
    tab[3] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 0);
    tab[4] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 0);
    tab[5] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 0);
    tab[6] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 2, 1, 0);
    tab[7] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 1);
    tab[8] = mk(1, 3, 4, 5, 0, 0, 0, 0, 1, 1, 2, 1, 1);
    for (int i = 9; i < 20; i++) tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 1);
    tab[20] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 5, 0, 1);
    for (int i = 21; i < 24; i++) tab[i] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 5, 0, 1);
    tab[24] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 5, 0, 1);
    tab[25] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0, 2);

    tick(); tick();
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_start", 32'(start_operation), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ops", 32'(ops_completed), 0);
    check("rst_timeout", 32'(timeout_error), 0);
    check("rst_dst", 32'(destination_register_index), 0);
    reset = 0; #1;
    check("rst_release_ready", 32'(instr_ready), 1);

    for (int i = 0; i < 26; i++) begin
      instr_valid = tab[i].v; instr_src0 = tab[i].s0; instr_src1 = tab[i].s1;
      instr_dst = tab[i].d; instr_use_src1 = tab[i].u; register_file_ready = tab[i].rf;
      tick();
      check($sformatf("row%0d_start", i), 32'(start_operation), 32'(tab[i].e_start));
      check($sformatf("row%0d_done", i), 32'(done_pulse), 32'(tab[i].e_done));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tab[i].e_busy));
      check($sformatf("row%0d_ready", i), 32'(instr_ready), 32'(tab[i].e_ready));
      check($sformatf("row%0d_dst", i), 32'(destination_register_index), 32'(tab[i].e_dst));
      check($sformatf("row%0d_use", i), 32'(use_source1), 32'(tab[i].e_use));
      check($sformatf("row%0d_ops", i), 32'(ops_completed), 32'(tab[i].e_ops));
    end
    instr_valid = 0;
    check("t1_src0", 32'(source0_register_index), 3);
    check("t1_src1", 32'(source1_register_index), 4);

    // three back-to-back ops
    push(1, 2, 6, 1); push(2, 3, 7, 0); push(3, 4, 8, 1);
    wait_dones(5, 100, "t2_dones");
    check("t2_busy_after", 32'(busy), 0);
    check("t2_ops", 32'(ops_completed), 5);
    for (int i = 0; i < 3; i++) check($sformatf("t2_order%0d", i), 32'(start_dst[2+i]), 32'(6+i));
    check("t2_start_after_done", order_err, 0);

    // back-pressure: FIFO_DEPTH queued plus one latched
    register_file_ready = 0;
    begin
      int acc = 0;
      logic r;
      for (int i = 0; i < 8; i++) begin
        instr_src0 = 1; instr_src1 = 2; instr_dst = RW'(i); instr_use_src1 = 1; instr_valid = 1;
        r = instr_ready;
        tick();
        if (r) acc++;
      end
      instr_valid = 0;
      check("t3_accepts", acc, 5);
    end
    check("t3_stalled", 32'(instr_ready), 0);
    check("t3_no_start", starts, 5);
    register_file_ready = 1;
    wait_dones(10, 200, "t3_dones");
    check("t3_ops", 32'(ops_completed), 10);
    for (int i = 0; i < 5; i++) check($sformatf("t3_order%0d", i), 32'(start_dst[5+i]), i);
    check("t3_start_after_done", order_err, 0);
    check("t3_ready_end", 32'(instr_ready), 1);

    // watchdog: FU never answers
    fu_en = 0;
    push(5, 6, 9, 1);
    wait_starts(11, 20, "t5_start");
    repeat (15) tick();
    check("t5_no_timeout_yet", 32'(timeout_error), 0);
    tick();
    check("t5_timeout", 32'(timeout_error), 1);
    check("t5_ready", 32'(instr_ready), 0);
    check("t5_busy", 32'(busy), 1);
    repeat (50) tick();
    check("t5_no_start", starts, 11);
    check("t5_sticky", 32'(timeout_error), 1);
    check("t5_ops", 32'(ops_completed), 10);
    reset = 1; #1;
    check("t5_rst_ready", 32'(instr_ready), 0);
    tick();
    reset = 0; #1;
    check("t5_cleared", 32'(timeout_error), 0);
    check("t5_ready_back", 32'(instr_ready), 1);

    // reset mid-RUN with two ops queued
    push(1, 1, 10, 1);
    wait_starts(1, 20, "t6_start");
    push(2, 2, 11, 0); push(3, 3, 12, 1);
    repeat (3) tick();
    check("t6_busy_before", 32'(busy), 1);
    reset = 1; #1;
    check("t6_ready_in_reset", 32'(instr_ready), 0);
    tick();
    check("t6_start", 32'(start_operation), 0);
    check("t6_done", 32'(done_pulse), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ops", 32'(ops_completed), 0);
    check("t6_timeout", 32'(timeout_error), 0);
    check("t6_dst", 32'(destination_register_index), 0);
    check("t6_use", 32'(use_source1), 0);
    reset = 0; fu_en = 1; #1;
    push(4, 5, 13, 1);
    wait_dones(1, 50, "t6_fresh_done");
    check("t6_fresh_ops", 32'(ops_completed), 1);
    check("t6_fresh_dst", 32'(destination_register_index), 13);
    check("t6_fresh_busy", 32'(busy), 0);
    check("t6_fresh_starts", starts, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
